loop_buffer_block_writer: RTL and testbench

- Upstream write-side stage for the async loop buffer. Takes a sop/eop-framed sample stream and writes each packet as one block at local addresses 0..2**WADDR_WIDTH-1.
- Ends each block with a one-cycle wr_wlast carrying a packed info word.
- Gates every block start on buffer space (free_size, wr_rdy) and stalls the source with s_rdy.
- Runs entirely in the buffer's write clock domain.

---
 rtl/loop_buffer_block_writer.sv | 118 +++++++++++
 tb/tb_loop_buffer_block_writer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/loop_buffer_block_writer.sv
// Write-side framer for the async loop buffer: turns a sop/eop sample stream into
// fixed-size blocks (optionally zero-padded) closed by a wlast pulse carrying an info word.
module loop_buffer_block_writer #(
    parameter int WDATA_WIDTH = 64,
    parameter int WADDR_WIDTH = 8,
    parameter int LOOP_WIDTH  = 9,
    parameter int INFO_WIDTH  = 256,
    parameter bit PAD_EN      = 1'b1
) (
    input  logic                                wr_clk,
    input  logic                                wr_rst,
    input  logic [WDATA_WIDTH-1:0]              s_data,
    input  logic                                s_vld,
    input  logic                                s_sop,
    input  logic                                s_eop,
    input  logic [INFO_WIDTH-WADDR_WIDTH-1:0]   s_info,
    output logic                                s_rdy,
    input  logic [LOOP_WIDTH-WADDR_WIDTH:0]     free_size,
    input  logic                                wr_rdy,
    output logic [WADDR_WIDTH-1:0]              wr_addr,
    output logic [WDATA_WIDTH-1:0]              wr_data,
    output logic                                wr_wen,
    output logic                                wr_wlast,
    output logic [INFO_WIDTH-1:0]               wr_info,
    output logic                                err_trunc,
    output logic [15:0]                         blk_cnt
);
    localparam int USER_WIDTH = INFO_WIDTH - WADDR_WIDTH;
    localparam logic [WADDR_WIDTH-1:0] IDX_MAX = '1;

    typedef enum logic [2:0] {IDLE, WRITE, DROP, PAD, LAST, GAP} state_t;

    state_t                  state, state_nxt;
    logic [WADDR_WIDTH-1:0]  idx;
    logic [WADDR_WIDTH-1:0]  len_m1;
    logic [USER_WIDTH-1:0]   user_info;
    logic                    accept;
    logic                    store;

    assign s_rdy  = (state == WRITE) || (state == DROP);
    assign accept = s_vld && s_rdy;
    // Words ahead of the first sop are thrown away so a block always starts on a packet.
    assign store  = (state == WRITE) && accept && ((idx != '0) || s_sop);

    always_ff @(posedge wr_clk) begin
        if (wr_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if ((free_size != '0) && wr_rdy) state_nxt = WRITE;
            WRITE: begin
                if (store) begin
                    if (s_eop)
                        state_nxt = (PAD_EN && (idx != IDX_MAX)) ? PAD : LAST;
                    else if (idx == IDX_MAX)
                        state_nxt = DROP;
                end
            end
            DROP:  if (accept && s_eop) state_nxt = LAST;
            PAD:   if (idx == IDX_MAX) state_nxt = LAST;
            LAST:  state_nxt = GAP;
            GAP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            idx       <= '0;
            len_m1    <= '0;
            user_info <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_wen    <= 1'b0;
            wr_wlast  <= 1'b0;
            wr_info   <= '0;
            err_trunc <= 1'b0;
            blk_cnt   <= '0;
        end else begin
            wr_wen   <= 1'b0;
            wr_wlast <= 1'b0;
            case (state)
                WRITE: begin
                    if (store) begin
                        wr_wen  <= 1'b1;
                        wr_addr <= idx;
                        wr_data <= s_data;
                        idx     <= idx + 1'b1;
                        if (idx == '0) user_info <= s_info;
                        if (s_eop) begin
                            len_m1 <= idx;
                        end else if (idx == IDX_MAX) begin
                            len_m1    <= idx;
                            err_trunc <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    wr_wen  <= 1'b1;
                    wr_addr <= idx;
                    wr_data <= '0;
                    idx     <= idx + 1'b1;
                end
                LAST: begin
                    // Registered so wlast lands the cycle after the final write, never with it.
                    wr_wlast <= 1'b1;
                    wr_info  <= {user_info, len_m1};
                    blk_cnt  <= blk_cnt + 16'd1;
                    idx      <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_loop_buffer_block_writer.sv
// Directed bench for loop_buffer_block_writer: one unpadded and one padded instance
// share the stream inputs; only the selected instance sees s_vld.
module tb_loop_buffer_block_writer;
    localparam int WD  = 64;
    localparam int WA  = 8;
    localparam int LW  = 9;
    localparam int IW  = 256;
    localparam int UW  = IW - WA;
    localparam int BLK = 1 << WA;

    typedef struct {
        logic [WA-1:0] addr;
        logic [WD-1:0] data;
    } wr_t;

    typedef struct {
        bit            sel;
        bit            rst;
        int            n;
        int            skip;
        logic [UW-1:0] info;
        logic [WD-1:0] base;
        int            exp_nwr;
        int            exp_len;
        bit            exp_err;
        int            exp_blk;
    } vec_t;

    logic           clk = 1'b0;
    logic           wr_rst;
    logic [WD-1:0]  s_data;
    logic           s_vld, s_sop, s_eop;
    logic [UW-1:0]  s_info;
    logic [LW-WA:0] free_size;
    logic           wr_rdy;
    bit             cur;

    logic           s_rdy0, s_rdy1, wen0, wen1, wlast0, wlast1, err0, err1;
    logic [WA-1:0]  addr0, addr1;
    logic [WD-1:0]  data0, data1;
    logic [IW-1:0]  info0, info1;
    logic [15:0]    blk0, blk1;

    int  vecs = 0;
    int  fails = 0;
    bit  overlap = 1'b0;
    wr_t wq0[$], wq1[$];
    logic [IW-1:0] lq0[$], lq1[$];

    always #5 clk = ~clk;

    loop_buffer_block_writer #(.WDATA_WIDTH(WD), .WADDR_WIDTH(WA), .LOOP_WIDTH(LW),
                               .INFO_WIDTH(IW), .PAD_EN(1'b0)) u_dut0 (
        .wr_clk(clk), .wr_rst(wr_rst), .s_data(s_data), .s_vld(s_vld && !cur),
        .s_sop(s_sop), .s_eop(s_eop), .s_info(s_info), .s_rdy(s_rdy0),
        .free_size(free_size), .wr_rdy(wr_rdy), .wr_addr(addr0), .wr_data(data0),
        .wr_wen(wen0), .wr_wlast(wlast0), .wr_info(info0), .err_trunc(err0), .blk_cnt(blk0));

    loop_buffer_block_writer #(.WDATA_WIDTH(WD), .WADDR_WIDTH(WA), .LOOP_WIDTH(LW),
                               .INFO_WIDTH(IW), .PAD_EN(1'b1)) u_dut1 (
        .wr_clk(clk), .wr_rst(wr_rst), .s_data(s_data), .s_vld(s_vld && cur),
        .s_sop(s_sop), .s_eop(s_eop), .s_info(s_info), .s_rdy(s_rdy1),
        .free_size(free_size), .wr_rdy(wr_rdy), .wr_addr(addr1), .wr_data(data1),
        .wr_wen(wen1), .wr_wlast(wlast1), .wr_info(info1), .err_trunc(err1), .blk_cnt(blk1));

    always @(negedge clk) begin
        if (wen0) wq0.push_back('{addr0, data0});
        if (wen1) wq1.push_back('{addr1, data1});
        if (wlast0) lq0.push_back(info0);
        if (wlast1) lq1.push_back(info1);
        if ((wen0 && wlast0) || (wen1 && wlast1)) overlap = 1'b1;
    end

    task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        wq0.delete(); wq1.delete(); lq0.delete(); lq1.delete();
    endtask

    task automatic do_reset();
        wr_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 wr_rst = 1'b0;
        clear_q();
    endtask

    task automatic send_word(input logic [WD-1:0] d, input logic sop, input logic eop);
        int   t;
        logic r;
        s_data = d; s_sop = sop; s_eop = eop; s_vld = 1'b1; t = 0;
        do begin
            @(negedge clk);
            r = cur ? s_rdy1 : s_rdy0;
            @(posedge clk);
            #1 t++;
        end while (!r && t < 2000);
        s_vld = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
        if (!r) chk("accept_timeout", 1, 0);
    endtask

    task automatic send_pkt(input int n, input int skip, input logic [UW-1:0] info,
                            input logic [WD-1:0] base);
        for (int j = 0; j < skip; j++) send_word(64'hDEAD_0000 + WD'(j), 1'b0, 1'b0);
        s_info = info;
        for (int k = 0; k < n; k++) send_word(base + WD'(k), k == 0, k == n - 1);
    endtask

    task automatic wait_last(input int exp_n);
        int t = 0;
        while ((cur ? lq1.size() : lq0.size()) < exp_n && t < 1000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 1000) chk("wlast_timeout", 1, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{0, 1,   4, 0, 248'h5,     64'hD0,   4,   3, 0, 1};
        tbl[1] = '{0, 0,   1, 0, 248'h1234,  64'hA00,  1,   0, 0, 2};
        tbl[2] = '{0, 0,   5, 3, 248'h77,    64'hB00,  5,   4, 0, 3};
        tbl[3] = '{1, 1,   3, 0, 248'hABC,   64'h100,  BLK, 2, 0, 1};
        tbl[4] = '{1, 0, 256, 0, 248'h9,     64'h2000, BLK, 255, 0, 2};
        tbl[5] = '{0, 1, 300, 0, 248'h33,    64'h3000, BLK, 255, 1, 1};
        tbl[6] = '{0, 0,   2, 0, 248'h44,    64'h4000, 2,   1, 1, 2};
        tbl[7] = '{1, 1, 300, 0, 248'h55,    64'h5000, BLK, 255, 1, 1};

        wr_rst = 1'b1; s_data = '0; s_vld = 0; s_sop = 0; s_eop = 0; s_info = '0;
        free_size = 2'd2; wr_rdy = 1'b1; cur = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {wen0, wlast0, err0, s_rdy0, blk0, addr0, data0, info0,
                              wen1, wlast1, err1, s_rdy1, blk1}, '0);
        do_reset();

        for (int v = 0; v < 8; v++) begin
            int  nst, bad;
            logic [WD-1:0] ed;
            wr_t w;
            cur = tbl[v].sel;
            if (tbl[v].rst) do_reset();
            clear_q();
            send_pkt(tbl[v].n, tbl[v].skip, tbl[v].info, tbl[v].base);
            wait_last(1);
            nst = (tbl[v].n < BLK) ? tbl[v].n : BLK;
            chk($sformatf("v%0d_nwrites", v), cur ? wq1.size() : wq0.size(), tbl[v].exp_nwr);
            bad = -1;
            for (int k = 0; k < tbl[v].exp_nwr; k++) begin
                if (k >= (cur ? wq1.size() : wq0.size())) break;
                w  = cur ? wq1[k] : wq0[k];
                ed = (k < nst) ? tbl[v].base + WD'(k) : '0;
                if (bad < 0 && (w.addr !== WA'(k) || w.data !== ed)) bad = k;
            end
            chk($sformatf("v%0d_write_first_bad_idx", v), bad, -1);
            chk($sformatf("v%0d_nwlast", v), cur ? lq1.size() : lq0.size(), 1);
            if ((cur ? lq1.size() : lq0.size()) > 0)
                chk($sformatf("v%0d_wr_info", v), cur ? lq1[0] : lq0[0],
                    {tbl[v].info, WA'(tbl[v].exp_len)});
            chk($sformatf("v%0d_err_trunc", v), cur ? err1 : err0, tbl[v].exp_err);
            chk($sformatf("v%0d_blk_cnt", v), cur ? blk1 : blk0, tbl[v].exp_blk);
        end

        // No space: hold IDLE, then release and check the one-cycle rdy latency.
        cur = 0;
        do_reset();
        free_size = '0;
        s_data = 64'hC0; s_sop = 1; s_eop = 0; s_info = 248'hC; s_vld = 1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("nospace_rdy", s_rdy0, 0);
        free_size = 2'd1; wr_rdy = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("wrrdy_low_rdy", s_rdy0, 0);
        chk("nospace_nowrites", wq0.size(), 0);
        @(posedge clk);
        #1 wr_rdy = 1'b1;
        @(negedge clk);
        chk("rdy_not_yet", s_rdy0, 0);
        @(negedge clk);
        chk("rdy_rises", s_rdy0, 1);
        s_vld = 0; s_sop = 0;
        @(posedge clk);
        #1 send_pkt(2, 0, 248'hC, 64'hC0);
        wait_last(1);
        chk("space_nwrites", wq0.size(), 2);
        if (wq0.size() == 2) chk("space_word1", {wq0[1].addr, wq0[1].data}, {8'd1, 64'hC1});
        free_size = 2'd2;

        // Reset in the middle of a block.
        do_reset();
        for (int k = 0; k < 10; k++) send_word(64'h500 + WD'(k), k == 0, 1'b0);
        wr_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_outputs", {wen0, wlast0, err0, blk0, addr0}, '0);
        @(negedge clk);
        chk("midrst_rdy", s_rdy0, 0);
        #1 wr_rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_wlast", lq0.size(), 0);
        clear_q();
        send_pkt(3, 0, 248'hE, 64'hE00);
        wait_last(1);
        if (wq0.size() > 0) chk("midrst_first_write", {wq0[0].addr, wq0[0].data}, {8'd0, 64'hE00});
        else chk("midrst_first_write_missing", 0, 1);
        chk("midrst_blk_cnt", blk0, 1);
        chk("wen_wlast_exclusive", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
